// File: rtl/tensor_core_scheduler.sv
// Round-robin front end and load/compute/respond sequencer that shares one small_tensor_core.
// Accept at T, LOAD at T+1, done honoured from T+3; the result is held until the owner accepts it and other requests wait.
module tensor_core_scheduler #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                      clock_in,
   input  logic                                      reset_n_in,
   input  logic [NUM_REQ-1:0]                        req_valid_in,
   output logic [NUM_REQ-1:0]                        req_ready_out,
   input  logic signed [NUM_REQ-1:0][3:0][3:0][7:0]  req_matrix_a_in,
   input  logic signed [NUM_REQ-1:0][3:0][3:0][7:0]  req_matrix_b_in,
   output logic [NUM_REQ-1:0]                        resp_valid_out,
   input  logic [NUM_REQ-1:0]                        resp_ready_in,
   output logic signed [3:0][3:0][7:0]               resp_matrix_out,
   output logic                                      resp_error_out,
   output logic                                      tensor_core_register_file_write_enable,
   output logic signed [3:0][3:0][7:0]               tensor_core_input1,
   output logic signed [3:0][3:0][7:0]               tensor_core_input2,
   input  logic signed [3:0][3:0][7:0]               tensor_core_output,
   input  logic                                      is_done_with_calculation,
   output logic                                      busy_out,
   output logic [$clog2(NUM_REQ)-1:0]                owner_out
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, RESPOND} state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   cycle_cnt;
   logic            grant_found;
   logic [OW-1:0]   grant_idx;
   logic [OW-1:0]   cand;
   logic            done_ok;
   logic            timed_out;

   // The done flag still reflects the previous job during the first COMPUTE cycle.
   assign done_ok   = (cycle_cnt != '0) && is_done_with_calculation;
   assign timed_out = (cycle_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = owner_out;
      cand        = owner_out;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = OW'((int'(owner_out) + i) % NUM_REQ);
         if (!grant_found && req_valid_in[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clock_in) begin
      if (!reset_n_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      req_ready_out = '0;
      case (state)
         IDLE: begin
            if (grant_found && reset_n_in) begin
               req_ready_out[grant_idx] = 1'b1;
               next_state               = LOAD;
            end
         end
         LOAD:    next_state = COMPUTE;
         COMPUTE: begin
            if (done_ok || timed_out) begin
               next_state = RESPOND;
            end
         end
         RESPOND: begin
            if (resp_ready_in[owner_out]) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (!reset_n_in) begin
         tensor_core_input1                     <= '0;
         tensor_core_input2                     <= '0;
         owner_out                              <= OW'(NUM_REQ - 1);
         cycle_cnt                              <= '0;
         resp_matrix_out                        <= '0;
         resp_error_out                         <= 1'b0;
         resp_valid_out                         <= '0;
         tensor_core_register_file_write_enable <= 1'b0;
         busy_out                               <= 1'b0;
      end else begin
         if (state == IDLE && grant_found) begin
            tensor_core_input1 <= req_matrix_a_in[grant_idx];
            tensor_core_input2 <= req_matrix_b_in[grant_idx];
            owner_out          <= grant_idx;
         end

         if (state == LOAD) begin
            cycle_cnt <= '0;
         end else if (state == COMPUTE) begin
            cycle_cnt <= cycle_cnt + CW'(1);
         end

         if (state == COMPUTE) begin
            if (done_ok) begin
               resp_matrix_out <= tensor_core_output;
               resp_error_out  <= 1'b0;
            end else if (timed_out) begin
               resp_matrix_out <= '0;
               resp_error_out  <= 1'b1;
            end
         end

         // Owner is frozen outside IDLE, so it is safe to steer the valid from it here.
         resp_valid_out <= '0;
         if (next_state == RESPOND) begin
            resp_valid_out[owner_out] <= 1'b1;
         end
         tensor_core_register_file_write_enable <= (next_state == LOAD);
         busy_out                               <= (next_state != IDLE);
      end
   end

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed bench for tensor_core_scheduler: the bench plays the tensor core and both requesters.
module tb_tensor_core_scheduler;
   localparam int NUM_REQ        = 2;
   localparam int TIMEOUT_CYCLES = 64;

   typedef logic signed [3:0][3:0][7:0] mat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                              reset_n;
   logic [1:0]                        req_valid;
   logic [1:0]                        req_ready;
   logic signed [1:0][3:0][3:0][7:0]  req_a;
   logic signed [1:0][3:0][3:0][7:0]  req_b;
   logic [1:0]                        resp_valid;
   logic [1:0]                        resp_ready;
   mat_t                              resp_matrix;
   logic                              resp_error;
   logic                              wr_en;
   mat_t                              core_in1;
   mat_t                              core_in2;
   mat_t                              core_out;
   logic                              done;
   logic                              busy;
   logic [0:0]                        owner;

   int checks   = 0;
   int failures = 0;

   tensor_core_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clock_in                               (clk),
      .reset_n_in                             (reset_n),
      .req_valid_in                           (req_valid),
      .req_ready_out                          (req_ready),
      .req_matrix_a_in                        (req_a),
      .req_matrix_b_in                        (req_b),
      .resp_valid_out                         (resp_valid),
      .resp_ready_in                          (resp_ready),
      .resp_matrix_out                        (resp_matrix),
      .resp_error_out                         (resp_error),
      .tensor_core_register_file_write_enable (wr_en),
      .tensor_core_input1                     (core_in1),
      .tensor_core_input2                     (core_in2),
      .tensor_core_output                     (core_out),
      .is_done_with_calculation               (done),
      .busy_out                               (busy),
      .owner_out                              (owner)
   );

   function automatic mat_t ident();
      mat_t m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = 8'd1;
      return m;
   endfunction

   function automatic mat_t ramp(input int base);
      mat_t m;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            m[i][j] = 8'(base + 4 * i + j);
      return m;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset_n    = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      done       = 1'b0;
      core_out   = '0;
      req_a      = '0;
      req_b      = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({req_ready, resp_valid, resp_error, wr_en, busy, owner} !== 8'b0000_0001) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, resp_valid, resp_error, wr_en, busy, owner}, 8'b0000_0001);
      end
      checks++;
      if (resp_matrix !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", resp_matrix); end
      checks++;
      if (core_in1 !== '0) begin failures++; $display("FAIL reset_in1 got=%h exp=0", core_in1); end
      checks++;
      if (core_in2 !== '0) begin failures++; $display("FAIL reset_in2 got=%h exp=0", core_in2); end
   endtask

   task automatic test_single_job();
      mat_t b;
      b = ramp(0);
      apply_reset();
      req_a[0] = ident(); req_b[0] = b; req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL single_accept got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00;                       // T+1: LOAD
      checks++;
      if ({wr_en, busy, owner} !== 3'b110) begin failures++; $display("FAIL single_load got=%b exp=110", {wr_en, busy, owner}); end
      checks++;
      if (core_in1 !== ident()) begin failures++; $display("FAIL single_in1 got=%h exp=%h", core_in1, ident()); end
      checks++;
      if (core_in2 !== b) begin failures++; $display("FAIL single_in2 got=%h exp=%h", core_in2, b); end
      tick();                                          // T+2: first COMPUTE
      checks++;
      if (wr_en !== 1'b0) begin failures++; $display("FAIL single_compute_we got=%b exp=0", wr_en); end
      for (int c = 2; c < 10; c++) begin
         checks++;
         if (resp_valid !== 2'b00) begin failures++; $display("FAIL single_early_valid cyc=%0d got=%b exp=00", c, resp_valid); end
         tick();
      end
      done = 1'b1; core_out = b;                       // T+10
      tick();                                          // T+11
      done = 1'b0; core_out = ramp(77);
      checks++;
      if ({resp_valid, resp_error} !== 3'b010) begin failures++; $display("FAIL single_resp got=%b exp=010", {resp_valid, resp_error}); end
      checks++;
      if (resp_matrix !== b) begin failures++; $display("FAIL single_result got=%h exp=%h", resp_matrix, b); end
      resp_ready = 2'b01;
      tick(); resp_ready = 2'b00;
      checks++;
      if ({resp_valid, busy} !== 3'b000) begin failures++; $display("FAIL single_idle got=%b exp=000", {resp_valid, busy}); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      mat_t       res;
      apply_reset();
      req_a[0] = ident(); req_b[0] = ramp(0); req_a[1] = ramp(3); req_b[1] = ident();
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
         res   = ramp(-8 + 16 * g);
         #1;
         checks++;
         if (req_ready !== exp_g) begin failures++; $display("FAIL contention_grant job=%0d got=%b exp=%b", g, req_ready, exp_g); end
         tick(); req_valid = req_valid & ~exp_g;      // LOAD
         tick(); done = 1'b1; core_out = res;         // first COMPUTE
         tick();
         tick(); done = 1'b0;                         // RESPOND
         checks++;
         if (resp_valid !== exp_g) begin failures++; $display("FAIL contention_resp job=%0d got=%b exp=%b", g, resp_valid, exp_g); end
         checks++;
         if (resp_matrix !== res) begin failures++; $display("FAIL contention_result job=%0d got=%h exp=%h", g, resp_matrix, res); end
         resp_ready = exp_g; req_valid = 2'b11;
         #1;
         checks++;
         if (req_ready !== 2'b00) begin failures++; $display("FAIL contention_handshake_grant job=%0d got=%b exp=00", g, req_ready); end
         tick(); resp_ready = 2'b00;
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_a[1] = ident(); req_b[1] = ramp(40); req_valid = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_accept got=%b exp=10", req_ready); end
      tick(); req_valid = 2'b00;
      tick(); done = 1'b1; core_out = ramp(40);
      tick();
      tick();                                          // RESPOND
      done = 1'b0; core_out = ramp(90); resp_ready = 2'b01; req_a[0] = ramp(5); req_valid = 2'b01;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({resp_valid, req_ready} !== 4'b1000) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b exp=1000", c, {resp_valid, req_ready}); end
         checks++;
         if (resp_matrix !== ramp(40)) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, resp_matrix, ramp(40)); end
         done = c[0];
         tick();
      end
      resp_ready = 2'b10;
      #1;
      checks++;
      if ({resp_valid, req_ready} !== 4'b1000) begin failures++; $display("FAIL bp_handshake got=%b exp=1000", {resp_valid, req_ready}); end
      tick(); resp_ready = 2'b00;
      #1;
      checks++;
      if ({resp_valid, req_ready} !== 4'b0001) begin failures++; $display("FAIL bp_next_accept got=%b exp=0001", {resp_valid, req_ready}); end
      req_valid = 2'b00; done = 1'b0;
      tick();
   endtask

   task automatic test_stale_done();
      apply_reset();
      done = 1'b1; core_out = ramp(60);
      req_a[0] = ramp(1); req_b[0] = ramp(2); req_valid = 2'b01;
      tick(); req_valid = 2'b00;                       // T+1: LOAD
      tick();                                          // T+2: first COMPUTE, stale done
      tick(); done = 1'b0;                             // T+3
      checks++;
      if (resp_valid !== 2'b00) begin failures++; $display("FAIL stale_ignored got=%b exp=00", resp_valid); end
      tick();
      tick(); done = 1'b1; core_out = ramp(-100);      // T+5
      tick(); done = 1'b0;                             // T+6
      checks++;
      if ({resp_valid, resp_error} !== 3'b010) begin failures++; $display("FAIL stale_resp got=%b exp=010", {resp_valid, resp_error}); end
      checks++;
      if (resp_matrix !== ramp(-100)) begin failures++; $display("FAIL stale_result got=%h exp=%h", resp_matrix, ramp(-100)); end
      resp_ready = 2'b01;
      tick(); resp_ready = 2'b00;
   endtask

   task automatic test_timeout();
      done = 1'b0; core_out = ramp(33); req_a[0] = ramp(7); req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL timeout_accept got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00;
      for (int c = 1; c < TIMEOUT_CYCLES + 2; c++) begin
         checks++;
         if (resp_valid !== 2'b00) begin failures++; $display("FAIL timeout_early cyc=%0d got=%b exp=00", c, resp_valid); end
         tick();
      end
      checks++;
      if ({resp_valid, resp_error} !== 3'b011) begin failures++; $display("FAIL timeout_resp got=%b exp=011", {resp_valid, resp_error}); end
      checks++;
      if (resp_matrix !== '0) begin failures++; $display("FAIL timeout_zero got=%h exp=0", resp_matrix); end
      resp_ready = 2'b01;
      tick(); resp_ready = 2'b00;
      req_a[1] = ramp(9); req_valid = 2'b10;
      tick(); req_valid = 2'b00;
      tick(); done = 1'b1; core_out = ramp(21);
      tick();
      tick(); done = 1'b0;
      checks++;
      if ({resp_valid, resp_error} !== 3'b100) begin failures++; $display("FAIL timeout_error_clear got=%b exp=100", {resp_valid, resp_error}); end
      resp_ready = 2'b10;
      tick(); resp_ready = 2'b00;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_a[0] = ramp(11); req_b[0] = ramp(12); req_valid = 2'b01; core_out = ramp(13);
      tick(); req_valid = 2'b00;
      tick();
      tick();                                          // mid-COMPUTE
      reset_n = 1'b0; done = 1'b1;
      tick(); reset_n = 1'b1;
      checks++;
      if ({req_ready, resp_valid, resp_error, wr_en, busy, owner} !== 8'b0000_0001) begin
         failures++;
         $display("FAIL midc_ctrl got=%b exp=%b", {req_ready, resp_valid, resp_error, wr_en, busy, owner}, 8'b0000_0001);
      end
      checks++;
      if (core_in1 !== '0) begin failures++; $display("FAIL midc_in1 got=%h exp=0", core_in1); end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (resp_valid !== 2'b00) begin failures++; $display("FAIL midc_no_resp cyc=%0d got=%b exp=00", c, resp_valid); end
         tick();
      end
      done = 1'b0; req_valid = 2'b01;
      tick(); req_valid = 2'b00;
      tick(); done = 1'b1;
      tick();
      tick(); done = 1'b0;                             // RESPOND
      checks++;
      if (resp_valid !== 2'b01) begin failures++; $display("FAIL midr_pre got=%b exp=01", resp_valid); end
      reset_n = 1'b0;
      tick(); reset_n = 1'b1;
      checks++;
      if ({req_ready, resp_valid, resp_error, wr_en, busy, owner} !== 8'b0000_0001) begin
         failures++;
         $display("FAIL midr_ctrl got=%b exp=%b", {req_ready, resp_valid, resp_error, wr_en, busy, owner}, 8'b0000_0001);
      end
      checks++;
      if (resp_matrix !== '0) begin failures++; $display("FAIL midr_result got=%h exp=0", resp_matrix); end
      checks++;
      if (core_in2 !== '0) begin failures++; $display("FAIL midr_in2 got=%h exp=0", core_in2); end
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL midr_first_grant got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_contention();
      test_backpressure();
      test_stale_done();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time_limit_reached checks=%0d", checks);
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/tensor_core_scheduler.md
# tensor_core_scheduler

Sequencing controller and round-robin arbiter that shares one `small_tensor_core` among `NUM_REQ` requesters. It accepts a pair of 4x4 signed 8-bit operand matrices from one requester at a time and latches them. It then runs the core's load/compute handshake, captures the 4x4 result when the core reports done, and returns the result to the owning requester with valid/ready flow control. It sits between the register-file/requester fabric and the tensor core, and is the only driver of the core's inputs.

## Interface
- `NUM_REQ`, 2: number of requesters (2..4).
- `TIMEOUT_CYCLES`, 64: compute cycles allowed before an error response is returned.

- `clock_in`  in  1  single clock; all state changes on the posedge.
- `reset_n_in`  in  1  synchronous, active-low reset.
- `req_valid_in`  in  [NUM_REQ]  per-requester job request.
- `req_ready_out`  out  [NUM_REQ]  per-requester accept strobe; one-hot or zero.
- `req_matrix_a_in`, `req_matrix_b_in`  in  [NUM_REQ][4][4] x 8 signed  operands per requester.
- `resp_valid_out`  out  [NUM_REQ]  result valid; one-hot to the owner.
- `resp_ready_in`  in  [NUM_REQ]  per-requester result accept.
- `resp_matrix_out`  out  [4][4] x 8 signed  captured result, shared by all requesters.
- `resp_error_out`  out  1  result produced by timeout; qualified by `resp_valid_out`.
- `tensor_core_register_file_write_enable`  out  1  core load/restart strobe.
- `tensor_core_input1`, `tensor_core_input2`  out  [4][4] x 8 signed  core operands.
- `tensor_core_output`  in  [4][4] x 8 signed  core result.
- `is_done_with_calculation`  in  1  core done flag.
- `busy_out`  out  1  high in every state except IDLE.
- `owner_out`  out  $clog2(NUM_REQ)  index of the current or last owner.

## Operation
- FSM states: IDLE, LOAD, COMPUTE, RESPOND.
- **IDLE**
  - Round-robin select among asserted `req_valid_in`. The search starts at `owner_out`+1 (mod NUM_REQ). After reset, requester 0 has top priority.
  - `req_ready_out[w]`=1 combinationally for winner w only. On that cycle A/B are latched into operand registers and `owner_out`<=w. Next state is LOAD.
  - No valid request: stay in IDLE, `req_ready_out`=0.
- **LOAD** (exactly 1 cycle)
  - `tensor_core_register_file_write_enable`=1, operand registers drive the core inputs, cycle counter cleared. Next state is COMPUTE.
- **COMPUTE**
  - Write enable is 0. Operands stay stable.
  - `is_done_with_calculation` is ignored in the first COMPUTE cycle, because it is stale from the previous job.
  - From the second COMPUTE cycle on, done=1 captures `tensor_core_output` into the result register, clears `resp_error_out`, and moves to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES without done: result register <= all zeros, `resp_error_out`<=1, move to RESPOND.
- **RESPOND**
  - `resp_valid_out[owner]`=1, and it holds with stable data until `resp_ready_in[owner]`=1.
  - On that handshake cycle the next state is IDLE. Arbitration resumes in the following cycle, so there is no back-to-back accept in the handshake cycle.
  - `resp_ready_in` of non-owners is ignored.
- Arithmetic: none in the block. Results pass through bit-exact; the core's 8-bit wrap is not altered.
- New `req_valid_in` while busy: held off with `req_ready_out`=0. Requesters must keep valid and operands stable until ready.

## Timing
- Reset (reset_n_in=0 at posedge) puts the block in IDLE and has priority over every other event, including mid-COMPUTE and mid-RESPOND. The in-flight job is dropped with no response.
- Reset values: `req_ready_out`=0, `resp_valid_out`=0, `resp_matrix_out`=0, `resp_error_out`=0, write enable=0, core inputs=0, `busy_out`=0, `owner_out`=NUM_REQ-1 (so requester 0 wins first).
- Latency: accept at cycle T; LOAD at T+1; COMPUTE from T+2. Done first sampled at T+3. Done seen at cycle D gives `resp_valid_out` at D+1.
- Timeout: error response valid at T+2+TIMEOUT_CYCLES.
- `req_ready_out` is combinational from state and `req_valid_in`. All other outputs are registered.

## Test plan
- Single job: requester 0, A=identity, B[i][j]=4i+j, done at T+10 -> `resp_valid_out`=2'b01 at T+11, result=B, error=0. Ready at once -> back in IDLE.
- Contention: both valid from reset, each resubmits after its response -> grant order 0,1,0,1. No grant occurs in the RESPOND handshake cycle.
- Backpressure: hold `resp_ready_in` low 5 cycles -> valid and result stable for all 5 cycles. A third request stays unaccepted.
- Stale done: done held 1 through LOAD and the first COMPUTE cycle, real result presented later -> the stale done is ignored and the later matrix is captured.
- Timeout: done stuck 0, TIMEOUT_CYCLES=64 -> error=1 and zero matrix at T+66.
- Reset mid-COMPUTE and mid-RESPOND -> all outputs at reset values next cycle, no response issued. The next job behaves as the first job after reset.
